// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier / restoring divider driving HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state_q;
  logic [1:0]         op_q;
  logic               sa_q, sb_q, bz_q, busy_q, done_q;
  logic [5:0]         cnt_q;
  logic [WIDTH-1:0]   a_q, m_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [WIDTH-1:0]   abs_a, abs_b, nr, quo, rem, hi_d, lo_d;
  logic [WIDTH:0]     sum, t;
  logic               sa, sb, ge;
  // p_q holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sa    = op[0] & a[WIDTH-1];
    sb    = op[0] & b[WIDTH-1];
    abs_a = sa ? -a : a;
    abs_b = sb ? -b : b;
    sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    t     = p_q[2*WIDTH-1:WIDTH-1];
    ge    = t >= {1'b0, m_q};
    nr    = ge ? WIDTH'(t - {1'b0, m_q}) : t[WIDTH-1:0];
    p_d   = op_q[1] ? {nr, p_q[WIDTH-2:0], ge} : {sum, p_q[WIDTH-1:1]};
    prod  = (sa_q ^ sb_q) ? -p_q : p_q;
    quo   = (sa_q ^ sb_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem   = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    hi_d  = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : bz_q ? a_q : rem;
    lo_d  = !op_q[1] ? prod[WIDTH-1:0] : bz_q ? '1 : quo;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_wen) hi_q <= wdata;
          if (lo_wen) lo_q <= wdata;
          if (start) begin
            op_q    <= op;
            sa_q    <= sa;
            sb_q    <= sb;
            bz_q    <= b == '0;
            a_q     <= a;
            m_q     <= op[1] ? abs_b : abs_a;
            p_q     <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(WIDTH - 1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table + scoreboard bench for muldiv_unit, with reset/interference sequences.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, hi_wen, lo_wen, busy, done;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  int          n_chk = 0, n_pass = 0, done_cnt = 0;
  typedef struct {logic [31:0] hi, lo;} exp_t;
  typedef struct {logic [1:0] op; logic [31:0] a, b, hi, lo;} vec_t;
  exp_t sbq[$];
  vec_t vt[10];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, req);
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    if (o[1] && y == 0) return {x, 32'hFFFF_FFFF};
    case (o)
      2'd0: return {32'b0, x} * {32'b0, y};
      2'd1: return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      2'd2: return {x % y, x / y};
      default: begin
        sx = $signed(x);
        sy = $signed(y);
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Scoreboard: every done pops one expected HI/LO pair
  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      done_cnt++;
      if (sbq.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
      else begin
        e = sbq.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit inj);
    int k = 0, nb = 0, d0 = done_cnt;
    sbq.push_back('{ehi, elo});
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && k < 100) begin
      if (busy) nb++;
      a = $urandom;
      b = $urandom;
      if (inj) begin
        start  = (k == 4);
        op     = 2'b11;
        hi_wen = (k == 9);
        wdata  = 32'hDEAD;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0; hi_wen = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_cycles", 64'(nb), 64'd33);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    logic [63:0] m;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          d0;
    vt[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[1] = '{2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vt[2] = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[4] = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
    vt[5] = '{2'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vt[6] = '{2'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vt[7] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vt[8] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[9] = '{2'd0, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780};
    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 2) ? 32'($urandom_range(1, 300)) : $urandom;
      m  = model(ro, ra, rb);
      run_op(ro, ra, rb, m[63:32], m[31:0], 1'b0);
    end
    hi_wen = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_wen = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'h55AA;
    @(negedge clk);
    hi_wen = 1'b0; lo_wen = 1'b0;
    chk("mthi_both", 64'(hi), 64'h55AA);
    chk("mtlo_both", 64'(lo), 64'h55AA);
    lo_wen = 1'b1; wdata = 32'h77;
    @(negedge clk);
    lo_wen = 1'b0;
    chk("mtlo_only_lo", 64'(lo), 64'h77);
    chk("mtlo_only_hi", 64'(hi), 64'h55AA);
    run_op(2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("inj_no_second_done", 64'(done_cnt - d0), 64'd0);
    chk("inj_hi_kept", 64'(hi), 64'd0);
    chk("inj_lo_kept", 64'(lo), 64'd6);
    lo_wen = 1'b1; hi_wen = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    lo_wen = 1'b0; hi_wen = 1'b0;
    d0 = done_cnt;
    op = 2'd0; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_op(2'd0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
